// File: rtl/load_store_unit.sv
`default_nettype none
// load_store_unit: single-outstanding data-memory access stage with store strobes and load formatting (rev 1.0).
// Optional MISALIGN_CHECK_EN: misaligned half/word accesses complete immediately with misaligned=1 and no bus request.
module load_store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ren,
  input  logic        wen,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] data_r,
  output logic        done,
  output logic        busy,
  output logic        bus_err,
  output logic        misaligned
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_REQ   = 2'd1;
  localparam logic [1:0]  S_DONE  = 2'd2;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic        load_q, load_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] maddr_q, maddr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;
  logic        mis_q, mis_d;

  logic [3:0]  strb_w;
  logic [31:0] rep_w;
  logic        mis_w;
  logic [31:0] lane_w;
  logic [31:0] fmt_w;

  // Store strobes and lane replication; funct3[1:0] carries the width, funct3[2] only the sign.
  always_comb begin
    strb_w = 4'b1111;
    rep_w  = wdata;
    case (funct3[1:0])
      2'b00: begin
        strb_w = 4'b0001 << addr[1:0];
        rep_w  = {4{wdata[7:0]}};
      end
      2'b01: begin
        strb_w = 4'b0011 << {addr[1], 1'b0};
        rep_w  = {2{wdata[15:0]}};
      end
      default: begin
        strb_w = 4'b1111;
        rep_w  = wdata;
      end
    endcase
  end

  always_comb begin
`ifdef MISALIGN_CHECK_EN
    mis_w = ((funct3[1:0] == 2'b01) && addr[0]) ||
            (funct3[1] && (addr[1:0] != 2'b00));
`else
    mis_w = 1'b0;
`endif
  end

  // Load formatting from the latched offset and width/sign code.
  always_comb begin
    lane_w = mem_rdata >> {off_q, 3'b000};
    fmt_w  = mem_rdata;
    case (f3_q[1:0])
      2'b00:   fmt_w = f3_q[2] ? {24'b0, lane_w[7:0]} : {{24{lane_w[7]}}, lane_w[7:0]};
      2'b01: begin
        if (off_q[1]) begin
          fmt_w = f3_q[2] ? {16'b0, mem_rdata[31:16]} : {{16{mem_rdata[31]}}, mem_rdata[31:16]};
        end else begin
          fmt_w = f3_q[2] ? {16'b0, mem_rdata[15:0]} : {{16{mem_rdata[15]}}, mem_rdata[15:0]};
        end
      end
      default: fmt_w = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    f3_d    = f3_q;
    load_d  = load_q;
    req_d   = req_q;
    we_d    = we_q;
    maddr_d = maddr_q;
    wstrb_d = wstrb_q;
    wdat_d  = wdat_q;
    data_d  = data_q;
    err_d   = err_q;
    mis_d   = mis_q;
    case (state_q)
      S_IDLE: begin
        if (start && (ren || wen)) begin
          off_d   = addr[1:0];
          f3_d    = funct3;
          load_d  = ren;
          maddr_d = {addr[31:2], 2'b00};
          wdat_d  = rep_w;
          cnt_d   = 16'd0;
          if (mis_w) begin
            mis_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            req_d   = 1'b1;
            we_d    = ~ren;
            wstrb_d = ren ? 4'b0000 : strb_w;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_ready) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          wstrb_d = 4'b0000;
          state_d = S_DONE;
          if (load_q) begin
            data_d = fmt_w;
          end
        end else if (cnt_q == TO_LAST) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          wstrb_d = 4'b0000;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        err_d   = 1'b0;
        mis_d   = 1'b0;
        cnt_d   = 16'd0;
        state_d = S_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      off_q   <= 2'b00;
      f3_q    <= 3'b000;
      load_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= 32'd0;
      wstrb_q <= 4'b0000;
      wdat_q  <= 32'd0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      load_q  <= load_d;
      req_q   <= req_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wstrb_q <= wstrb_d;
      wdat_q  <= wdat_d;
      data_q  <= data_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
    end
  end

  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = maddr_q;
  assign mem_wstrb  = wstrb_q;
  assign mem_wdata  = wdat_q;
  assign data_r     = data_q;
  assign done       = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign bus_err    = err_q;
  assign misaligned = mis_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// tb_load_store_unit: directed transactions checked against a transaction-level model (rev 1.0).
module tb_load_store_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, start, ren, wen, mem_ready;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic        mem_req, mem_we, done, busy, bus_err, misaligned;
  logic [31:0] mem_addr, mem_wdata, data_r;
  logic [3:0]  mem_wstrb;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .ren(ren), .wen(wen), .funct3(funct3),
    .addr(addr), .wdata(wdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .data_r(data_r), .done(done), .busy(busy), .bus_err(bus_err), .misaligned(misaligned)
  );

  logic        cmp_en = 1'b0;
  logic        exp_load, exp_err, exp_mis;
  logic [31:0] exp_addr, exp_wdata, exp_fmt, model_data;
  logic [3:0]  exp_wstrb;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;
  logic        cap_we, cap_err, cap_mis;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fmt_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    case (f3[1:0])
      2'b00: begin
        v = (rd >> (8 * a[1:0])) & 32'hFF;
        if (!f3[2] && v >= 32'h80) v = v - 32'h100;
      end
      2'b01: begin
        v = (rd >> (16 * a[1])) & 32'hFFFF;
        if (!f3[2] && v >= 32'h8000) v = v - 32'h10000;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  task automatic set_model(input logic r, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int waitc);
    logic [31:0] b, h;
    b = wd & 32'hFF;
    h = wd & 32'hFFFF;
    exp_load = r;
    exp_mis  = 1'b0;
`ifdef MISALIGN_CHECK_EN
    if (f3[1:0] == 2'b01 && a[0]) exp_mis = 1'b1;
    if (f3[1] && a[1:0] != 2'b00) exp_mis = 1'b1;
`endif
    exp_err  = !exp_mis && (waitc >= TO);
    exp_addr = a & 32'hFFFF_FFFC;
    case (f3[1:0])
      2'b00:   begin exp_wstrb = 4'(1 << a[1:0]);          exp_wdata = b * 32'h0101_0101; end
      2'b01:   begin exp_wstrb = a[1] ? 4'b1100 : 4'b0011; exp_wdata = h * 32'h0001_0001; end
      default: begin exp_wstrb = 4'b1111;                   exp_wdata = wd;                end
    endcase
    if (r) exp_wstrb = 4'b0000;
    exp_fmt = fmt_model(f3, a, rd);
  endtask

  // Per-cycle comparison of the bus and result against the model.
  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      if (mem_req) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_we", 32'(mem_we), 32'(!exp_load));
        chk("mem_wstrb", 32'(mem_wstrb), 32'(exp_wstrb));
        if (!exp_load) chk("mem_wdata", mem_wdata, exp_wdata);
      end
      if (done) begin
        chk("bus_err", 32'(bus_err), 32'(exp_err));
        chk("misaligned", 32'(misaligned), 32'(exp_mis));
        if (exp_load && !exp_err && !exp_mis) model_data = exp_fmt;
      end
      chk("data_r", data_r, model_data);
    end
  end

  task automatic run_txn(input logic r, input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd, input int waitc,
                         input logic poke, output int reqc, output int lat);
    @(negedge clk);
    start = 1'b1; ren = r; wen = w; funct3 = f3; addr = a; wdata = wd; mem_rdata = rd;
    set_model(r, f3, a, wd, rd, waitc);
    reqc = 0;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 50) begin
      chk("busy_inflight", 32'(busy), 32'd1);
      if (poke) begin
        start = (lat == 2);
        if (lat == 2) begin addr = 32'h7777_0001; wen = 1'b1; ren = 1'b0; funct3 = 3'b010; end
      end
      if (mem_req) begin
        if (reqc == 0) begin
          cap_addr = mem_addr; cap_wdata = mem_wdata; cap_wstrb = mem_wstrb; cap_we = mem_we;
        end
        mem_ready = (reqc == waitc);
        reqc++;
      end else begin
        mem_ready = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    mem_ready = 1'b0;
    start = 1'b0;
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_wait: no done within %0d cycles", lat);
    end else begin
      chk("busy_at_done", 32'(busy), 32'd1);
      cap_err = bus_err;
      cap_mis = misaligned;
    end
    @(negedge clk);
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_pulse", 32'(done), 32'd0);
  endtask

  int rq, lt;

  initial begin
    rst = 1'b1; start = 1'b0; ren = 1'b0; wen = 1'b0; funct3 = 3'b000;
    addr = 32'd0; wdata = 32'd0; mem_rdata = 32'd0; mem_ready = 1'b0;
    model_data = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_data_r", data_r, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_misaligned", 32'(misaligned), 32'd0);
    cmp_en = 1'b1;

    run_txn(1'b1, 1'b0, 3'b000, 32'h1003, 32'd0, 32'h80FF_1234, 0, 1'b0, rq, lt);
    chk("lb_latency", lt, 2); chk("lb_reqc", rq, 1);
    chk("lb_addr", cap_addr, 32'h1000); chk("lb_data", data_r, 32'hFFFF_FF80);

    run_txn(1'b1, 1'b0, 3'b100, 32'h1003, 32'd0, 32'h80FF_1234, 0, 1'b0, rq, lt);
    chk("lbu_data", data_r, 32'h0000_0080);

    run_txn(1'b1, 1'b0, 3'b101, 32'h2002, 32'd0, 32'hBEEF_0001, 3, 1'b0, rq, lt);
    chk("lhu_reqc", rq, 4); chk("lhu_latency", lt, 5); chk("lhu_data", data_r, 32'h0000_BEEF);

    run_txn(1'b0, 1'b1, 3'b000, 32'h3001, 32'h1234_56AB, 32'd0, 0, 1'b0, rq, lt);
    chk("sb_we", 32'(cap_we), 32'd1); chk("sb_wstrb", 32'(cap_wstrb), 32'h2);
    chk("sb_wdata", cap_wdata, 32'hABAB_ABAB); chk("sb_data_hold", data_r, 32'h0000_BEEF);

    run_txn(1'b0, 1'b1, 3'b001, 32'h3002, 32'h1234_56AB, 32'd0, 0, 1'b0, rq, lt);
    chk("sh_wstrb", 32'(cap_wstrb), 32'hC); chk("sh_wdata", cap_wdata, 32'h56AB_56AB);

    run_txn(1'b0, 1'b1, 3'b010, 32'h3000, 32'h1234_56AB, 32'd0, 1, 1'b0, rq, lt);
    chk("sw_wstrb", 32'(cap_wstrb), 32'hF); chk("sw_wdata", cap_wdata, 32'h1234_56AB);

    run_txn(1'b1, 1'b0, 3'b010, 32'h4002, 32'd0, 32'hCAFE_F00D, 0, 1'b0, rq, lt);
`ifdef MISALIGN_CHECK_EN
    chk("lw_mis_latency", lt, 1); chk("lw_mis_reqc", rq, 0);
    chk("lw_mis_flag", 32'(cap_mis), 32'd1); chk("lw_mis_data", data_r, 32'h0000_BEEF);
`else
    chk("lw_mis_addr", cap_addr, 32'h4000); chk("lw_mis_data", data_r, 32'hCAFE_F00D);
`endif

    run_txn(1'b1, 1'b0, 3'b001, 32'h5000, 32'd0, 32'h1234_8765, 0, 1'b0, rq, lt);
    chk("lh_data", data_r, 32'hFFFF_8765);

    run_txn(1'b1, 1'b1, 3'b000, 32'h5002, 32'hFFFF_FFFF, 32'h1234_8765, 0, 1'b0, rq, lt);
    chk("rw_we", 32'(cap_we), 32'd0); chk("rw_wstrb", 32'(cap_wstrb), 32'd0);
    chk("rw_data", data_r, 32'h0000_0034);

    run_txn(1'b1, 1'b0, 3'b011, 32'h5000, 32'd0, 32'h89AB_CDEF, 0, 1'b0, rq, lt);
    chk("f3_011_data", data_r, 32'h89AB_CDEF);

    run_txn(1'b1, 1'b0, 3'b010, 32'h6000, 32'd0, 32'h1111_1111, 1000, 1'b0, rq, lt);
    chk("to_reqc", rq, 4); chk("to_latency", lt, 5);
    chk("to_bus_err", 32'(cap_err), 32'd1); chk("to_data_hold", data_r, 32'h89AB_CDEF);

    run_txn(1'b1, 1'b0, 3'b010, 32'h6000, 32'd0, 32'h2222_2222, 3, 1'b0, rq, lt);
    chk("last_reqc", rq, 4); chk("last_bus_err", 32'(cap_err), 32'd0);
    chk("last_data", data_r, 32'h2222_2222);

    run_txn(1'b1, 1'b0, 3'b101, 32'h5003, 32'd0, 32'hA1B2_C3D4, 0, 1'b0, rq, lt);
`ifdef MISALIGN_CHECK_EN
    chk("lhu_mis_data", data_r, 32'h2222_2222);
`else
    chk("lhu_mis_data", data_r, 32'h0000_A1B2);
`endif

    run_txn(1'b1, 1'b0, 3'b010, 32'h7000, 32'd0, 32'h0BAD_F00D, 3, 1'b1, rq, lt);
    chk("poke_reqc", rq, 4); chk("poke_data", data_r, 32'h0BAD_F00D);

    @(negedge clk); start = 1'b1; ren = 1'b0; wen = 1'b0;
    @(negedge clk); start = 1'b0;
    chk("nop_busy", 32'(busy), 32'd0); chk("nop_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("nop_done", 32'(done), 32'd0);

    @(negedge clk);
    start = 1'b1; ren = 1'b1; wen = 1'b0; funct3 = 3'b010; addr = 32'h8000; mem_rdata = 32'd0;
    set_model(1'b1, 3'b010, 32'h8000, 32'd0, 32'd0, 1000);
    @(negedge clk); start = 1'b0;
    chk("rst_mid_req_before", 32'(mem_req), 32'd1);
    @(negedge clk); cmp_en = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0; model_data = 32'd0;
    chk("rst_mid_req", 32'(mem_req), 32'd0); chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0); chk("rst_mid_data", data_r, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_no_done", 32'(done), 32'd0); chk("rst_mid_no_req", 32'(mem_req), 32'd0);
    end
    cmp_en = 1'b1;

    run_txn(1'b1, 1'b0, 3'b100, 32'h8001, 32'd0, 32'h0000_AB00, 0, 1'b0, rq, lt);
    chk("post_rst_latency", lt, 2); chk("post_rst_data", data_r, 32'h0000_00AB);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
